ps2_dir_decoder: RTL
====================

Name: ps2_dir_decoder

Overview:
- Parametrised PS/2 scancode-to-direction decoder for N players.
- Sits between ps2_keyboard and game_logic.
- Tracks the E0 (extended) and F0 (break) prefixes, looks up a per-player 4-key keymap, latches one direction per player, suppresses typematic repeats, and generates the round-restart pulse.
- Replaces hand-written per-player key decoding in the top level.

Parameters:
- NUM_PLAYERS, 4, number of players (1..8).
- KEYMAP, 4-player table below, NUM_PLAYERS*4*9 bits. Entry index e=p*4+d occupies bits [9*e +: 9] = {ext, code[7:0]}, where d is UP=0, DOWN=1, LEFT=2, RIGHT=3. Default table:
  - p0: 1D, 1B, 1C, 23
  - p1: ext 75, ext 72, ext 6B, ext 74
  - p2: 2C, 34, 2B, 33
  - p3: 43, 42, 3B, 4B
- HOME_DIRS, 8'h1B, NUM_PLAYERS*2 bits. Direction per player after reset or restart; p0 in the LSBs. Default gives p0=RIGHT, p1=LEFT, p2=DOWN, p3=UP.
- RESTART_CODE, 8'h29, non-extended restart key (space).

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- code_new  in  1  ps2_keyboard new-code flag; same clock domain; level, acted on at its rising edge
- code  in  8  scancode byte, valid when code_new rises
- dir  out  NUM_PLAYERS*2  latched direction per player, p0 in [1:0]
- dir_changed  out  NUM_PLAYERS  one-cycle pulse per player whose dir value changed
- game_reset  out  1  one-cycle pulse on restart-key release

Behaviour:
- Reset values:
  - dir=HOME_DIRS, dir_changed=0, game_reset=0.
  - prefix FSM=S_IDLE, held mask (NUM_PLAYERS*4 bits)=0, code_new edge register=0.
  - reset has priority over a simultaneous event.
- Edge detect: the event cycle E is when code_new=1 and the registered code_new from the previous cycle is 0. code is sampled in cycle E. Every output effect is visible from cycle E+1. Pulses last exactly one cycle; there is no other latency.
- Prefix FSM, states S_IDLE, S_EXT, S_BRK, S_EXT_BRK:
  - E0: IDLE->EXT, BRK->EXT_BRK, otherwise stay.
  - F0: IDLE->BRK, EXT->EXT_BRK, otherwise stay.
  - Any other byte is the key byte: ext=(state is EXT or EXT_BRK), brk=(state is BRK or EXT_BRK). It is processed, then the FSM returns to S_IDLE.
  - E1 and unmapped bytes are processed as non-matches; the FSM still returns to S_IDLE.
- Make (brk=0) matching entry e={ext,code}:
  - If held[e]=1: ignored as a typematic repeat.
  - Otherwise: set held[e] and request dir[p]=d.
  - If one code maps to two directions of the same player, the lowest d wins.
  - Every player whose entry matches updates in the same cycle.
- Break matching entry e: clear held[e]. dir is unchanged.
- Restart key make (ext=0, code=RESTART_CODE): dir=HOME_DIRS for all players; held mask unchanged.
- Restart key break: game_reset=1 for one cycle. A make of the restart key never asserts game_reset. An extended 29 is a non-match.
- dir_changed[p] is asserted only if the new dir[p] differs from the old value. A request equal to the current direction produces no pulse.
- Break of an unheld key: no effect. Mid-sequence reset (after E0/F0, before the key byte): FSM returns to S_IDLE and the prefix is discarded.

Optional Feature:
- Macro: PS2_DIR_REVERSE_BLOCK_EN.
- Defined: a make requesting the exact opposite of the current dir[p] (UP<->DOWN, LEFT<->RIGHT) is dropped. dir and dir_changed are unchanged; held[e] is still set. Restart-key homing is not subject to this check.
- Undefined: opposite-direction requests are accepted like any other.

Test Plan:
- After reset, code sequence 1D -> dir[1:0]=0 (UP), dir_changed=4'b0001 for exactly one cycle at E+1; other players keep their HOME_DIRS values.
- E0,75 -> dir[3:2]=UP. Non-extended 75 alone -> no change and no pulse. E0,F0,75 -> held cleared, dir unchanged.
- 1D,1D,1D (no break) -> one dir_changed pulse total. Then F0,1D followed by 1D -> no pulse, because the direction is already UP.
- Change dirs, then 29 -> dir=8'h1B with pulses for the changed players and game_reset=0. Then F0,29 -> game_reset=1 for one cycle. E0,F0,29 -> no game_reset.
- With PS2_DIR_REVERSE_BLOCK_EN: p0 is RIGHT, key 1C (LEFT) -> dir[1:0] stays 3, no pulse. Without the macro -> dir[1:0]=2 with a pulse.
- Send F0, assert reset for one cycle, then send 23 -> treated as a make: held set, p0 dir=RIGHT.

Source files
------------

// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder
// -----------------------------------------------------------------------------
// Turns the PS/2 scancode stream from ps2_keyboard into one latched direction
// per player for game_logic. It tracks the E0 (extended) and F0 (break)
// prefixes, matches the key byte against a per-player 4-key keymap, suppresses
// typematic repeats with a held-key mask, homes every player on the restart
// key make, and pulses game_reset on the restart key release.
//
// Optional feature (macro PS2_DIR_REVERSE_BLOCK_EN):
//   When defined, a make that requests the exact opposite of a player's
//   current direction is dropped. The key is still marked held. Restart
//   homing bypasses this check.
//
// Parameters:
//   NUM_PLAYERS  - number of players (1..8)
//   KEYMAP       - NUM_PLAYERS*4 entries of {ext, code[7:0]}. Entry e=p*4+d
//                  sits at [9*e +: 9]; d is UP=0, DOWN=1, LEFT=2, RIGHT=3
//   HOME_DIRS    - direction per player after reset/restart, p0 in the LSBs
//   RESTART_CODE - non-extended restart key
//
// Ports:
//   clock       in   system clock (CLOCK_50 domain)
//   reset       in   synchronous, active-high
//   code_new    in   new-code flag (level); acted on at its rising edge
//   code        in   scancode byte, sampled in the rising-edge cycle
//   dir         out  latched direction per player, p0 in [1:0]
//   dir_changed out  one-cycle pulse per player whose dir value changed
//   game_reset  out  one-cycle pulse on restart key release
// -----------------------------------------------------------------------------
module ps2_dir_decoder #(
    parameter int                          NUM_PLAYERS  = 4,
    parameter logic [NUM_PLAYERS*36-1:0]   KEYMAP       = {
        9'h04B, 9'h03B, 9'h042, 9'h043,     // p3: RIGHT LEFT DOWN UP
        9'h033, 9'h02B, 9'h034, 9'h02C,     // p2
        9'h174, 9'h16B, 9'h172, 9'h175,     // p1 (extended arrows)
        9'h023, 9'h01C, 9'h01B, 9'h01D      // p0
    },
    parameter logic [NUM_PLAYERS*2-1:0]    HOME_DIRS    = 8'h1B,
    parameter logic [7:0]                  RESTART_CODE = 8'h29
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       code_new,
    input  logic [7:0]                 code,
    output logic [NUM_PLAYERS*2-1:0]   dir,
    output logic [NUM_PLAYERS-1:0]     dir_changed,
    output logic                       game_reset
);

    localparam int NUM_ENTRIES = NUM_PLAYERS * 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t                     state_reg, state_next;
    logic                       code_new_reg;
    logic [NUM_ENTRIES-1:0]     held_reg, held_next;
    logic [NUM_PLAYERS*2-1:0]   dir_reg, dir_next;
    logic [NUM_PLAYERS-1:0]     dir_changed_reg, dir_changed_next;
    logic                       game_reset_reg, game_reset_next;

    logic                       code_event;
    logic                       is_e0, is_f0;
    logic                       key_event;
    logic                       key_ext, key_brk;
    logic                       restart_make;
    logic [NUM_ENTRIES-1:0]     entry_hit;
    logic [NUM_ENTRIES-1:0]     make_new;

    assign code_event = code_new & ~code_new_reg;
    assign is_e0      = (code == 8'hE0);
    assign is_f0      = (code == 8'hF0);
    // Anything that is not a prefix byte ends the sequence, mapped or not.
    assign key_event  = code_event & ~is_e0 & ~is_f0;
    assign key_ext    = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);
    assign key_brk    = (state_reg == S_BRK) || (state_reg == S_EXT_BRK);

    assign restart_make    = key_event & ~key_ext & ~key_brk & (code == RESTART_CODE);
    assign game_reset_next = key_event & ~key_ext &  key_brk & (code == RESTART_CODE);

    // Prefix FSM
    always_comb begin
        state_next = state_reg;
        if (code_event) begin
            if (is_e0) begin
                case (state_reg)
                    S_IDLE:  state_next = S_EXT;
                    S_BRK:   state_next = S_EXT_BRK;
                    default: state_next = state_reg;
                endcase
            end else if (is_f0) begin
                case (state_reg)
                    S_IDLE:  state_next = S_BRK;
                    S_EXT:   state_next = S_EXT_BRK;
                    default: state_next = state_reg;
                endcase
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    // Per-entry keymap match and held-mask update. A make sets the bit, a
    // break clears it; breaking an unheld key leaves it clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign entry_hit[gi] = key_event && (KEYMAP[9*gi +: 9] == {key_ext, code});
            assign held_next[gi] = entry_hit[gi] ? ~key_brk : held_reg[gi];
            // Only a make of a key not already held is a fresh request.
            assign make_new[gi]  = entry_hit[gi] & ~key_brk & ~held_reg[gi];
        end
    endgenerate

    // Per-player direction update
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [3:0] req;
            logic [1:0] cur_dir;
            logic [1:0] req_dir;
            logic       req_valid;
            logic       req_ok;
            logic [1:0] player_next;

            assign req       = make_new[4*gi +: 4];
            assign cur_dir   = dir_reg[2*gi +: 2];
            assign req_valid = |req;
            // Lowest direction index wins when one code maps to several.
            assign req_dir   = req[0] ? 2'd0 :
                               req[1] ? 2'd1 :
                               req[2] ? 2'd2 : 2'd3;
`ifdef PS2_DIR_REVERSE_BLOCK_EN
            // Opposites differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
            assign req_ok    = req_valid && (req_dir != (cur_dir ^ 2'b01));
`else
            assign req_ok    = req_valid;
`endif
            assign player_next = restart_make ? HOME_DIRS[2*gi +: 2] :
                                 req_ok       ? req_dir              : cur_dir;

            assign dir_next[2*gi +: 2]  = player_next;
            assign dir_changed_next[gi] = (player_next != cur_dir);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            code_new_reg    <= 1'b0;
            held_reg        <= '0;
            dir_reg         <= HOME_DIRS;
            dir_changed_reg <= '0;
            game_reset_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            code_new_reg    <= code_new;
            held_reg        <= held_next;
            dir_reg         <= dir_next;
            dir_changed_reg <= dir_changed_next;
            game_reset_reg  <= game_reset_next;
        end
    end

    assign dir         = dir_reg;
    assign dir_changed = dir_changed_reg;
    assign game_reset  = game_reset_reg;

endmodule
